// File: rtl/approx_div_error_monitor.sv
// Error monitor for the 16/8 approximate array divider: recomputes the exact
// quotient/remainder with a restoring divider and accumulates error statistics.
module approx_div_error_monitor #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      n,
  input  logic [7:0]       d,
  input  logic [7:0]       q_apx,
  input  logic [7:0]       r_apx,
  output logic             out_valid,
  output logic             skipped,
  output logic [7:0]       q_exact,
  output logic [7:0]       r_exact,
  output logic [8:0]       q_err,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] skip_count,
  output logic [ACC_W-1:0] err_sum_sq,
  output logic [7:0]       err_max
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ACC
  } state_t;

  state_t      state;
  logic [7:0]  n_lo_r;
  logic [7:0]  d_r;
  logic [7:0]  qa_r;
  logic [7:0]  ra_r;
  logic [7:0]  p_r;
  logic [7:0]  qbits;
  logic [2:0]  iter;
  logic        skip_r;

  logic [8:0]     t_val;
  logic [7:0]     t_sub;
  logic           t_ge;
  logic [8:0]     err_c;
  logic [7:0]     abs_c;
  logic [15:0]    sq_c;
  logic [ACC_W:0] sum_ext;
  logic           mis_c;

  assign in_ready = (state == S_IDLE);

  // Only n[7:0] is kept: the high byte seeds the partial remainder at accept.
  // In range, P < d holds every step, so T - d always fits in 8 bits.
  always_comb begin
    t_val   = {p_r, n_lo_r[iter]};
    t_ge    = (t_val >= {1'b0, d_r});
    t_sub   = t_val[7:0] - d_r;
    err_c   = {1'b0, qa_r} - {1'b0, qbits};
    abs_c   = err_c[8] ? (8'd0 - err_c[7:0]) : err_c[7:0];
    sq_c    = {8'd0, abs_c} * {8'd0, abs_c};
    sum_ext = {1'b0, err_sum_sq} + {{(ACC_W + 1 - 16){1'b0}}, sq_c};
    mis_c   = (qa_r != qbits) || (ra_r != p_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      n_lo_r         <= '0;
      d_r            <= '0;
      qa_r           <= '0;
      ra_r           <= '0;
      p_r            <= '0;
      qbits          <= '0;
      iter           <= '0;
      skip_r         <= 1'b0;
      out_valid      <= 1'b0;
      skipped        <= 1'b0;
      q_exact        <= '0;
      r_exact        <= '0;
      q_err          <= '0;
      sample_count   <= '0;
      mismatch_count <= '0;
      skip_count     <= '0;
      err_sum_sq     <= '0;
      err_max        <= '0;
    end else if (clear) begin
      state          <= S_IDLE;
      n_lo_r         <= '0;
      d_r            <= '0;
      qa_r           <= '0;
      ra_r           <= '0;
      p_r            <= '0;
      qbits          <= '0;
      iter           <= '0;
      skip_r         <= 1'b0;
      out_valid      <= 1'b0;
      skipped        <= 1'b0;
      q_exact        <= '0;
      r_exact        <= '0;
      q_err          <= '0;
      sample_count   <= '0;
      mismatch_count <= '0;
      skip_count     <= '0;
      err_sum_sq     <= '0;
      err_max        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n_lo_r <= n[7:0];
            d_r    <= d;
            qa_r   <= q_apx;
            ra_r   <= r_apx;
            if ((d != 8'd0) && (n[15:8] < d)) begin
              state  <= S_DIV;
              iter   <= 3'd7;
              p_r    <= n[15:8];
              skip_r <= 1'b0;
            end else begin
              state  <= S_ACC;
              skip_r <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (t_ge) begin
            p_r         <= t_sub;
            qbits[iter] <= 1'b1;
          end else begin
            p_r         <= t_val[7:0];
            qbits[iter] <= 1'b0;
          end
          if (iter == 3'd0) state <= S_ACC;
          else              iter  <= iter - 3'd1;
        end
        S_ACC: begin
          out_valid <= 1'b1;
          skipped   <= skip_r;
          state     <= S_IDLE;
          if (skip_r) begin
            q_exact <= '0;
            r_exact <= '0;
            q_err   <= '0;
            if (~&skip_count) skip_count <= skip_count + CNT_W'(1);
          end else begin
            q_exact <= qbits;
            r_exact <= p_r;
            q_err   <= err_c;
            if (~&sample_count) sample_count <= sample_count + CNT_W'(1);
            if (mis_c && ~&mismatch_count)
              mismatch_count <= mismatch_count + CNT_W'(1);
            err_sum_sq <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (abs_c > err_max) err_max <= abs_c;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_div_error_monitor.sv
// Self-checking bench for approx_div_error_monitor: directed vectors, random
// samples against an arithmetic reference model, and clear/reset/saturation cases.
module tb_approx_div_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] n = '0;
  logic [7:0]  d = '0;
  logic [7:0]  q_apx = '0;
  logic [7:0]  r_apx = '0;

  logic        in_ready, out_valid, skipped;
  logic [7:0]  q_exact, r_exact, err_max;
  logic [8:0]  q_err;
  logic [23:0] sample_count, mismatch_count, skip_count;
  logic [39:0] err_sum_sq;

  logic        in_ready2, out_valid2, skipped2;
  logic [7:0]  q_exact2, r_exact2, err_max2;
  logic [8:0]  q_err2;
  logic [23:0] sample_count2, mismatch_count2, skip_count2;
  logic [16:0] err_sum_sq2;

  approx_div_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
    .out_valid(out_valid), .skipped(skipped), .q_exact(q_exact), .r_exact(r_exact),
    .q_err(q_err), .sample_count(sample_count), .mismatch_count(mismatch_count),
    .skip_count(skip_count), .err_sum_sq(err_sum_sq), .err_max(err_max)
  );

  approx_div_error_monitor #(.ACC_W(17)) dut_w17 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
    .out_valid(out_valid2), .skipped(skipped2), .q_exact(q_exact2), .r_exact(r_exact2),
    .q_err(q_err2), .sample_count(sample_count2), .mismatch_count(mismatch_count2),
    .skip_count(skip_count2), .err_sum_sq(err_sum_sq2), .err_max(err_max2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_samp, m_mis, m_skip, m_sum, m_sum2, m_max;
  localparam longint SUM_CAP  = 64'd1099511627775;
  localparam longint SUM2_CAP = 64'd131071;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d, qa, ra;
    bit          skip;
    int          q, r, err;
  } vec_t;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d, qa, ra;
    int          cyc;
  } tup_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_samp = 0; m_mis = 0; m_skip = 0; m_sum = 0; m_sum2 = 0; m_max = 0;
  endtask

  // Reference: exact division by plain integer arithmetic, statistics as numbers.
  task automatic model_apply(input logic [15:0] nn, input logic [7:0] dd, qa, ra,
                             output bit es, output int eq, output int er, output int ee);
    int nv, dv, sq, ae;
    nv = int'(nn); dv = int'(dd);
    es = !(dv != 0 && (nv / 256) < dv);
    if (es) begin
      eq = 0; er = 0; ee = 0;
      m_skip++;
    end else begin
      eq = nv / dv; er = nv % dv; ee = int'(qa) - eq;
      ae = (ee < 0) ? -ee : ee;
      sq = ae * ae;
      m_samp++;
      if (int'(qa) != eq || int'(ra) != er) m_mis++;
      m_sum  = (m_sum + sq > SUM_CAP) ? SUM_CAP : m_sum + sq;
      m_sum2 = (m_sum2 + sq > SUM2_CAP) ? SUM2_CAP : m_sum2 + sq;
      if (ae > m_max) m_max = ae;
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_sample_count"}, sample_count, m_samp);
    chk({tag, "_mismatch_count"}, mismatch_count, m_mis);
    chk({tag, "_skip_count"}, skip_count, m_skip);
    chk({tag, "_err_sum_sq"}, err_sum_sq, m_sum);
    chk({tag, "_err_sum_sq_w17"}, err_sum_sq2, m_sum2);
    chk({tag, "_err_max"}, err_max, m_max);
  endtask

  task automatic chk_result(input string tag, input bit es, input int eq, er, ee);
    chk({tag, "_skipped"}, skipped, es);
    chk({tag, "_q_exact"}, q_exact, eq);
    chk({tag, "_r_exact"}, r_exact, er);
    chk({tag, "_q_err"}, $signed(q_err), ee);
    chk_stats(tag);
  endtask

  // Called away from a clock edge with the monitor idle; returns after the output pulse ended.
  task automatic send(input string tag, input logic [15:0] nn, input logic [7:0] dd, qa, ra);
    bit es, got;
    int eq, er, ee, lat;
    chk({tag, "_in_ready"}, in_ready, 1);
    n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_apply(nn, dd, qa, ra, es, eq, er, ee);
    got = 1'b0; lat = -1;
    for (int k = 1; k <= 15 && !got; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; lat = k; end
    end
    chk({tag, "_latency"}, lat, es ? 1 : 9);
    if (got) begin
      chk_result(tag, es, eq, er, ee);
      @(posedge clk); #1;
      chk({tag, "_pulse_width"}, out_valid, 0);
    end
  endtask

  task automatic chk_zeroed(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_q_exact"}, q_exact, 0);
    chk({tag, "_r_exact"}, r_exact, 0);
    chk({tag, "_q_err"}, q_err, 0);
    chk({tag, "_skipped"}, skipped, 0);
    chk_stats(tag);
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk({tag, "_no_out_valid"}, seen, 0);
  endtask

  task automatic rand_tuple(input bit in_range, output logic [15:0] nn, output logic [7:0] dd, qa, ra);
    int dv, hi, q, r, off;
    if (in_range) begin
      dv = $urandom_range(1, 255);
      hi = $urandom_range(0, dv - 1);
    end else begin
      dv = $urandom_range(0, 255);
      hi = $urandom_range(dv, 255);
    end
    nn = 16'(hi * 256 + int'($urandom_range(0, 255)));
    dd = 8'(dv);
    q  = (dv != 0) ? int'(nn) / dv : 0;
    r  = (dv != 0) ? int'(nn) % dv : 0;
    off = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 8)) - 4;
    qa = 8'(q + off);
    ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    longint sat_exp[4];
    logic [15:0] tn;
    logic [7:0]  td, tqa, tra;
    tup_t pend[$];
    tup_t cur;
    int acc_cyc[$];
    bit es;
    int eq, er, ee;

    tbl[0] = '{n: 16'h1234, d: 8'h56, qa: 8'h36, ra: 8'h10, skip: 1'b0, q: 54,  r: 16, err: 0};
    tbl[1] = '{n: 16'h1234, d: 8'h56, qa: 8'd50, ra: 8'h10, skip: 1'b0, q: 54,  r: 16, err: -4};
    tbl[2] = '{n: 16'h00FF, d: 8'h01, qa: 8'h00, ra: 8'h00, skip: 1'b0, q: 255, r: 0,  err: -255};
    tbl[3] = '{n: 16'h1234, d: 8'h00, qa: 8'h12, ra: 8'h34, skip: 1'b1, q: 0,   r: 0,  err: 0};
    tbl[4] = '{n: 16'h1000, d: 8'h10, qa: 8'hFF, ra: 8'h00, skip: 1'b1, q: 0,   r: 0,  err: 0};
    sat_exp[0] = 65025; sat_exp[1] = 130050; sat_exp[2] = 131071; sat_exp[3] = 131071;

    model_reset();
    #12;
    chk_zeroed("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send($sformatf("vec%0d", i), tbl[i].n, tbl[i].d, tbl[i].qa, tbl[i].ra);
      chk($sformatf("vec%0d_tbl_skipped", i), skipped, tbl[i].skip);
      chk($sformatf("vec%0d_tbl_q", i), q_exact, tbl[i].q);
      chk($sformatf("vec%0d_tbl_r", i), r_exact, tbl[i].r);
      chk($sformatf("vec%0d_tbl_err", i), $signed(q_err), tbl[i].err);
    end
    chk("tbl_err_sum_sq", err_sum_sq, 65041);
    chk("tbl_err_max", err_max, 255);
    chk("tbl_sample_count", sample_count, 3);
    chk("tbl_mismatch_count", mismatch_count, 2);
    chk("tbl_skip_count", skip_count, 2);

    for (int i = 0; i < 25; i++) begin
      rand_tuple($urandom_range(0, 4) != 0, tn, td, tqa, tra);
      send($sformatf("rnd%0d", i), tn, td, tqa, tra);
    end

    // Backpressure: new tuple every cycle, only those seen while ready are accepted.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (pend.size() == 0) chk("bp_unexpected_out_valid", 1, 0);
        else begin
          cur = pend.pop_front();
          model_apply(cur.n, cur.d, cur.qa, cur.ra, es, eq, er, ee);
          chk_result("bp", es, eq, er, ee);
        end
      end
      rand_tuple(1'b1, tn, td, tqa, tra);
      n = tn; d = td; q_apx = tqa; r_apx = tra; in_valid = 1'b1;
      if (in_ready) begin
        pend.push_back('{n: tn, d: td, qa: tqa, ra: tra, cyc: c});
        acc_cyc.push_back(c);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12 && pend.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        cur = pend.pop_front();
        model_apply(cur.n, cur.d, cur.qa, cur.ra, es, eq, er, ee);
        chk_result("bp_drain", es, eq, er, ee);
      end
    end
    chk("bp_pending_left", pend.size(), 0);
    chk("bp_accepts", acc_cyc.size(), 6);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("bp_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 10);
    @(posedge clk); #1;

    // clear together with an accept drops the tuple
    n = 16'h1234; d = 8'h56; q_apx = 8'h36; r_apx = 8'h10; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    model_reset();
    chk_zeroed("clr_accept");
    no_pulse("clr_accept", 12);

    // clear while DIV processes bit 3
    send("pre_clr", 16'h00FF, 8'h01, 8'h10, 8'h00);
    n = 16'h2345; d = 8'h77; q_apx = 8'h10; r_apx = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    chk_zeroed("clr_div");
    no_pulse("clr_div", 12);

    // asynchronous reset mid-DIV
    send("pre_rst", 16'h00FF, 8'h01, 8'h20, 8'h00);
    n = 16'h3456; d = 8'h99; q_apx = 8'h10; r_apx = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_zeroed("async_rst");
    @(negedge clk); rst_n = 1'b1;
    no_pulse("async_rst", 12);

    // 17-bit accumulator saturates and sticks
    for (int i = 0; i < 4; i++) begin
      send($sformatf("sat%0d", i), 16'h00FF, 8'h01, 8'h00, 8'h00);
      chk($sformatf("sat%0d_w17_sum", i), err_sum_sq2, sat_exp[i]);
    end
    chk("sat_main_sum", err_sum_sq, 260100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
